// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the command-ring streamer: FSM states, word size
// and the ring-configuration sanity check.
package gpu_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_COMP_REQ,
    ST_ERR
  } state_e;

  localparam logic [31:0] CMD_WORD_BYTES = 32'd4;

  // A ring is unusable if it is empty or anything is not word aligned.
  function automatic logic cfg_bad(input logic [31:0] size,
                                   input logic [1:0]  base_lo,
                                   input logic [1:0]  cons_lo);
    return (size == '0) || (size[1:0] != 2'b00) ||
           (base_lo != 2'b00) || (cons_lo != 2'b00);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; push and pop may coincide,
// including when full.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/cmd_streamer.sv
// Fetches 32-bit command words from a memory ring between the consumer and
// producer pointers, buffers them in a FIFO and reports progress by writing back.
module cmd_streamer
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_enable,
  input  logic [31:0]   cmd_ring_base,
  input  logic [31:0]   cmd_ring_size_bytes,
  input  logic [31:0]   cmd_cons_ptr_bytes,
  input  logic [31:0]   cmd_completion_base,
  input  logic [31:0]   prod_ptr_bytes,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [31:0]   mem_req_wdata,
  input  logic          mem_rsp_valid,
  input  logic [31:0]   mem_rsp_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [31:0]   cmd_data,
  output logic [31:0]   cons_ptr,
  output logic          busy,
  output logic          err_cfg
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic          enable_q;
  logic [31:0]   cons_q, cons_d;
  logic [31:0]   cons_inc, cons_next, fetch_addr;
  logic          en_rise, push, pop, fifo_empty, fifo_full, full_after;
  logic [CW-1:0] fifo_count;

  assign en_rise    = cmd_enable & ~enable_q;
  assign cons_inc   = cons_q + CMD_WORD_BYTES;
  assign cons_next  = (cons_inc >= cmd_ring_size_bytes) ? '0 : cons_inc;
  assign fetch_addr = cmd_ring_base + cons_q;
  assign pop        = cmd_valid & cmd_ready;
  // The push under way fills the FIFO unless a pop drains one slot this cycle.
  assign full_after = (fifo_count == DEPTH_C - CW'(1)) & ~pop;

  always_comb begin
    state_d       = state_q;
    cons_d        = cons_q;
    push          = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_rise) begin
          if (cfg_bad(cmd_ring_size_bytes, cmd_ring_base[1:0], cmd_cons_ptr_bytes[1:0]))
            state_d = ST_ERR;
        end else if (cmd_enable && (cons_q != prod_ptr_bytes) && (fifo_count < DEPTH_C)) begin
          state_d = ST_FETCH_REQ;
        end
      end
      ST_FETCH_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = AW'(fetch_addr);
        if (mem_req_ready) state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        if (mem_rsp_valid) begin
          push   = 1'b1;
          cons_d = cons_next;
          if (!cmd_enable)                                  state_d = ST_IDLE;
          else if ((cons_next == prod_ptr_bytes) || full_after) state_d = ST_COMP_REQ;
          else                                              state_d = ST_FETCH_REQ;
        end
      end
      ST_COMP_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = AW'(cmd_completion_base);
        mem_req_wdata = cons_q;
        if (mem_req_ready) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (!cmd_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (en_rise) cons_d = cmd_cons_ptr_bytes;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      cons_q   <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= cmd_enable;
      cons_q   <= cons_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (mem_rsp_data),
    .rdata (cmd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign cmd_valid = ~fifo_empty;
  assign cons_ptr  = cons_q;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
  assign err_cfg   = (state_q == ST_ERR);

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_cmd_streamer.sv
// Self-checking bench for cmd_streamer: directed ring scenarios plus randomized
// rings checked against a pointer-walk reference model.
module tb_cmd_streamer;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_enable;
  logic [31:0] cmd_ring_base, cmd_ring_size_bytes, cmd_cons_ptr_bytes, cmd_completion_base;
  logic [31:0] prod_ptr_bytes;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_data, cons_ptr;
  logic        busy, err_cfg;

  int unsigned total = 0;
  int unsigned bad   = 0;

  req_t        req_q[$];
  logic [31:0] cmd_q[$];
  int unsigned rdy_mode = 0;   // 0: always ready, 1: random, 2: never
  int unsigned rsp_max  = 0;
  bit          hold_rsp = 1'b0;

  cmd_streamer #(
    .FIFO_DEPTH (4),
    .AW         (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_enable          (cmd_enable),
    .cmd_ring_base       (cmd_ring_base),
    .cmd_ring_size_bytes (cmd_ring_size_bytes),
    .cmd_cons_ptr_bytes  (cmd_cons_ptr_bytes),
    .cmd_completion_base (cmd_completion_base),
    .prod_ptr_bytes      (prod_ptr_bytes),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_we          (mem_req_we),
    .mem_req_addr        (mem_req_addr),
    .mem_req_wdata       (mem_req_wdata),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_data            (cmd_data),
    .cons_ptr            (cons_ptr),
    .busy                (busy),
    .err_cfg             (err_cfg)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory slave and command sink; acts half a cycle before each sampling edge.
  task automatic mem_model();
    bit          pend = 1'b0;
    int unsigned cnt  = 0;
    logic [31:0] paddr = '0;
    req_t        r;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (pend) begin
        if (cnt != 0) cnt--;
        else if (!hold_rsp) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(paddr);
          pend = 1'b0;
        end
      end
      case (rdy_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = 1'($urandom_range(0, 1));
        default: mem_req_ready = 1'b0;
      endcase
      if (mem_req_valid && mem_req_ready && !rst) begin
        r.we    = mem_req_we;
        r.addr  = mem_req_addr;
        r.wdata = mem_req_we ? mem_req_wdata : 32'h0;
        req_q.push_back(r);
        if (!mem_req_we) begin
          pend  = 1'b1;
          paddr = mem_req_addr;
          cnt   = $urandom_range(0, rsp_max);
        end
      end
      if (cmd_valid && cmd_ready && !rst) cmd_q.push_back(cmd_data);
    end
  endtask

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int unsigned quiet = 0, cyc = 0;
    while (quiet < 4 && cyc < 2000) begin
      tick(1);
      cyc++;
      quiet = busy ? 0 : quiet + 1;
    end
    check("idle_reached", 65'(quiet >= 4), 65'(1));
  endtask

  task automatic wait_reqs(input int unsigned n);
    int unsigned cyc = 0;
    while (req_q.size() < n && cyc < 500) begin
      tick(1);
      cyc++;
    end
    check("req_seen", 65'(req_q.size() >= n), 65'(1));
  endtask

  task automatic configure(input logic [31:0] base, size, cons, prod, comp);
    cmd_ring_base       = base;
    cmd_ring_size_bytes = size;
    cmd_cons_ptr_bytes  = cons;
    prod_ptr_bytes      = prod;
    cmd_completion_base = comp;
  endtask

  // Reference: walk the ring from 'from' to 'to' word by word, wrapping at size.
  task automatic check_reads(input logic [31:0] base, size, from, to, comp, input bit with_comp);
    req_t        exp_q[$];
    req_t        e;
    logic [31:0] p = from;
    int unsigned n;
    while (p != to && exp_q.size() < 64) begin
      e.we = 1'b0; e.addr = base + p; e.wdata = 32'h0;
      exp_q.push_back(e);
      p = p + 4;
      if (p >= size) p = 0;
    end
    if (with_comp) begin
      e.we = 1'b1; e.addr = comp; e.wdata = to;
      exp_q.push_back(e);
    end
    check("req_count", 65'(req_q.size()), 65'(exp_q.size()));
    n = (req_q.size() < exp_q.size()) ? req_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) check("req", req_q[i], exp_q[i]);
    req_q.delete();
  endtask

  task automatic check_cmds(input logic [31:0] base, size, from, to);
    logic [31:0] exp_q[$];
    logic [31:0] p = from;
    int unsigned n;
    while (p != to && exp_q.size() < 64) begin
      exp_q.push_back(mem_word(base + p));
      p = p + 4;
      if (p >= size) p = 0;
    end
    check("cmd_count", 65'(cmd_q.size()), 65'(exp_q.size()));
    n = (cmd_q.size() < exp_q.size()) ? cmd_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) check("cmd", 65'(cmd_q[i]), 65'(exp_q[i]));
    cmd_q.delete();
  endtask

  initial begin
    logic [31:0] rb, rs, rc, rp, rcomp;
    int unsigned w;

    rst = 1'b1; cmd_enable = 1'b0; cmd_ready = 1'b0;
    configure(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    fork mem_model(); join_none

    // Reset state
    tick(3);
    check("rst_valid", 65'(mem_req_valid), 65'(0));
    check("rst_cmd_valid", 65'(cmd_valid), 65'(0));
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_err", 65'(err_cfg), 65'(0));
    check("rst_cons", 65'(cons_ptr), 65'(0));
    rst = 1'b0;
    tick(2);

    // Basic fetch of two words
    cmd_ready = 1'b1;
    configure(32'h1000, 32'h40, 32'h0, 32'h8, 32'h2000);
    cmd_enable = 1'b1;
    wait_idle();
    check_reads(32'h1000, 32'h40, 32'h0, 32'h8, 32'h2000, 1'b1);
    check_cmds(32'h1000, 32'h40, 32'h0, 32'h8);
    check("basic_cons", 65'(cons_ptr), 65'(32'h8));
    cmd_enable = 1'b0; tick(2);

    // Wrap around the end of the ring
    configure(32'h3000, 32'h10, 32'hC, 32'h4, 32'h2100);
    cmd_enable = 1'b1;
    wait_idle();
    check_reads(32'h3000, 32'h10, 32'hC, 32'h4, 32'h2100, 1'b1);
    check_cmds(32'h3000, 32'h10, 32'hC, 32'h4);
    check("wrap_cons", 65'(cons_ptr), 65'(32'h4));
    cmd_enable = 1'b0; tick(2);

    // Backpressure: FIFO fills after four words, completion reports 0x10
    cmd_ready = 1'b0;
    configure(32'h4000, 32'h40, 32'h0, 32'h18, 32'h2200);
    cmd_enable = 1'b1;
    tick(60);
    check_reads(32'h4000, 32'h40, 32'h0, 32'h10, 32'h2200, 1'b1);
    check("bp_no_pop", 65'(cmd_q.size()), 65'(0));
    check("bp_cons", 65'(cons_ptr), 65'(32'h10));
    check("bp_cmd_valid", 65'(cmd_valid), 65'(1));
    cmd_ready = 1'b1;
    wait_idle();
    check_reads(32'h4000, 32'h40, 32'h10, 32'h18, 32'h2200, 1'b1);
    check_cmds(32'h4000, 32'h40, 32'h0, 32'h18);
    cmd_enable = 1'b0; tick(2);

    // Request held while memory is not ready
    rdy_mode = 2;
    configure(32'h5000, 32'h20, 32'h0, 32'h4, 32'h2300);
    cmd_enable = 1'b1;
    for (int unsigned c = 0; c < 100 && !mem_req_valid; c++) tick(1);
    for (int unsigned i = 0; i < 5; i++) begin
      check("stall_valid", 65'(mem_req_valid), 65'(1));
      check("stall_addr", 65'(mem_req_addr), 65'(32'h5000));
      check("stall_we", 65'(mem_req_we), 65'(0));
      tick(1);
    end
    rdy_mode = 0;
    wait_idle();
    check_reads(32'h5000, 32'h20, 32'h0, 32'h4, 32'h2300, 1'b1);
    check_cmds(32'h5000, 32'h20, 32'h0, 32'h4);
    cmd_enable = 1'b0; tick(2);

    // Configuration errors: zero size, then misaligned base
    configure(32'h1000, 32'h0, 32'h0, 32'h8, 32'h2000);
    cmd_enable = 1'b1; tick(3);
    check("err_size", 65'(err_cfg), 65'(1));
    tick(5);
    check("err_size_noreq", 65'(req_q.size()), 65'(0));
    cmd_enable = 1'b0; tick(2);
    check("err_size_clr", 65'(err_cfg), 65'(0));
    configure(32'h1002, 32'h40, 32'h0, 32'h8, 32'h2000);
    cmd_enable = 1'b1; tick(8);
    check("err_base", 65'(err_cfg), 65'(1));
    check("err_base_noreq", 65'(req_q.size()), 65'(0));
    cmd_enable = 1'b0; tick(2);
    check("err_base_clr", 65'(err_cfg), 65'(0));

    // Disable while waiting for read data: word kept, no completion
    hold_rsp = 1'b1;
    configure(32'h6000, 32'h40, 32'h0, 32'h10, 32'h2400);
    cmd_enable = 1'b1;
    wait_reqs(1);
    tick(2);
    cmd_enable = 1'b0;
    tick(3);
    check("dis_wait_valid", 65'(mem_req_valid), 65'(0));
    check("dis_wait_busy", 65'(busy), 65'(1));
    hold_rsp = 1'b0;
    wait_idle();
    check_reads(32'h6000, 32'h40, 32'h0, 32'h4, 32'h2400, 1'b0);
    check_cmds(32'h6000, 32'h40, 32'h0, 32'h4);
    check("dis_cons", 65'(cons_ptr), 65'(32'h4));

    // Reset while waiting for read data: late response dropped
    hold_rsp = 1'b1;
    configure(32'h7000, 32'h40, 32'h8, 32'h10, 32'h2500);
    cmd_enable = 1'b1;
    wait_reqs(1);
    tick(2);
    rst = 1'b1; cmd_enable = 1'b0;
    tick(1);
    rst = 1'b0; hold_rsp = 1'b0;
    tick(6);
    check("rstw_cmd_valid", 65'(cmd_valid), 65'(0));
    check("rstw_busy", 65'(busy), 65'(0));
    check("rstw_cons", 65'(cons_ptr), 65'(0));
    check("rstw_valid", 65'(mem_req_valid), 65'(0));
    check("rstw_reqs", 65'(req_q.size()), 65'(1));
    check("rstw_cmds", 65'(cmd_q.size()), 65'(0));
    req_q.delete();
    cmd_q.delete();

    // Randomized rings with random memory stalls and latency
    rdy_mode = 1; rsp_max = 3; cmd_ready = 1'b1;
    for (int unsigned it = 0; it < 20; it++) begin
      w     = $urandom_range(1, 16);
      rs    = 32'(w * 4);
      rc    = 32'($urandom_range(0, w - 1) * 4);
      rp    = 32'($urandom_range(0, w - 1) * 4);
      rb    = $urandom & 32'hFFFF_FFFC;
      rcomp = $urandom & 32'hFFFF_FFFC;
      configure(rb, rs, rc, rp, rcomp);
      cmd_enable = 1'b1;
      wait_idle();
      check_reads(rb, rs, rc, rp, rcomp, rc != rp);
      check_cmds(rb, rs, rc, rp);
      check("rand_cons", 65'(cons_ptr), 65'(rp));
      cmd_enable = 1'b0; tick(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
